// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_pkg;

  // Controller states: wait for a request, hold the RAM inputs, report completion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Requester identities: instruction fetch (read-only) and load/store.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  // The chip select is the top CHIP_FIELD_W bits of the address.
  localparam int CHIP_FIELD_W = 8;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers the last granted port so ties alternate.
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic       grant_valid_o,
  output port_e      grant_port_o
);

  port_e lastGrant_q;

  // Pick the sole requester, or on a tie the port that did not win last time.
  always_comb begin
    grant_valid_o = |req_i;
    grant_port_o  = PORT_IF;
    if (req_i == 2'b11) begin
      grant_port_o = (lastGrant_q == PORT_LS) ? PORT_IF : PORT_LS;
    end else if (req_i[1]) begin
      grant_port_o = PORT_LS;
    end
  end

  // Remember every issued grant; reset favours port 0 on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant_q <= PORT_LS;
    end else if (grant_en_i && grant_valid_o) begin
      lastGrant_q <= grant_port_o;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one level-sensitive 8-chip RAM between the fetch port and the load/store port.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int NUM_CHIPS     = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CHIP_FIELD_W-1:0] CHIP_LIMIT = CHIP_FIELD_W'(NUM_CHIPS);

  state_e            state_q;
  port_e             port_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ifAck_q, lsAck_q, ifErr_q, lsErr_q, memRw_q;
  logic [DATA_W-1:0] ifRdata_q, lsRdata_q, memWdata_q;
  logic [ADDR_W-1:0] memAddr_q;

  logic              grantValid;
  port_e             grantPort;
  logic [ADDR_W-1:0] selAddr;
  logic              selWe;
  logic              selBad;

  rr_arb2 uArb (
    .clk           (clk),
    .reset         (reset),
    .req_i         ({ls_req, if_req}),
    .grant_en_i    (state_q == IDLE),
    .grant_valid_o (grantValid),
    .grant_port_o  (grantPort)
  );

  // Steer the winning port's request fields and decode whether its chip exists.
  always_comb begin
    selAddr = (grantPort == PORT_LS) ? ls_addr : if_addr;
    selWe   = (grantPort == PORT_LS) && ls_we;
    selBad  = selAddr[ADDR_W-1 -: CHIP_FIELD_W] >= CHIP_LIMIT;
  end

  // Access sequencer: latch on grant, hold the RAM inputs, then pulse the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      port_q     <= PORT_IF;
      cnt_q      <= '0;
      ifAck_q    <= 1'b0;
      lsAck_q    <= 1'b0;
      ifErr_q    <= 1'b0;
      lsErr_q    <= 1'b0;
      ifRdata_q  <= '0;
      lsRdata_q  <= '0;
      memRw_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      ifAck_q <= 1'b0;
      lsAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            port_q <= grantPort;
            if (selBad) begin
              state_q <= RESP;
              if (grantPort == PORT_LS) begin
                lsAck_q   <= 1'b1;
                lsErr_q   <= 1'b1;
                lsRdata_q <= '0;
              end else begin
                ifAck_q   <= 1'b1;
                ifErr_q   <= 1'b1;
                ifRdata_q <= '0;
              end
            end else begin
              state_q   <= ACCESS;
              cnt_q     <= CNT_LOAD;
              memAddr_q <= selAddr;
              memRw_q   <= selWe;
              if (grantPort == PORT_LS) begin
                memWdata_q <= ls_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            memRw_q <= 1'b0;
            if (port_q == PORT_LS) begin
              lsAck_q <= 1'b1;
              lsErr_q <= 1'b0;
              if (!memRw_q) begin
                lsRdata_q <= mem_rdata;
              end
            end else begin
              ifAck_q <= 1'b1;
              ifErr_q <= 1'b0;
              if (!memRw_q) begin
                ifRdata_q <= mem_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_ack    = ifAck_q;
  assign if_err    = ifErr_q;
  assign if_rdata  = ifRdata_q;
  assign ls_ack    = lsAck_q;
  assign ls_err    = lsErr_q;
  assign ls_rdata  = lsRdata_q;
  assign mem_rw    = memRw_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus reset, tie and short-window sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic        if_req, if_ack, if_err, ls_req, ls_we, ls_ack, ls_err, mem_rw;
  logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req2, if_ack2, if_err2, ls_req2, ls_we2, ls_ack2, ls_err2, mem_rw2;
  logic [31:0] if_addr2, if_rdata2, ls_addr2, ls_wdata2, ls_rdata2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2;

  logic [31:0] ram [256];

  int nVec = 0;
  int nMiss = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          expLat;
    logic        expErr;
    logic [31:0] expRdata;
    int          expRw;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  mem_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ACCESS_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset),
    .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2), .if_rdata(if_rdata2), .if_err(if_err2),
    .ls_req(ls_req2), .ls_we(ls_we2), .ls_addr(ls_addr2), .ls_wdata(ls_wdata2),
    .ls_ack(ls_ack2), .ls_rdata(ls_rdata2), .ls_err(ls_err2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rw(mem_rw2), .mem_rdata(mem_rdata2)
  );

  // RAM word index: 3 chip bits and 5 word bits.
  function automatic logic [7:0] ramIdx(input logic [31:0] a);
    return {a[26:24], a[6:2]};
  endfunction

  // Level-sensitive RAM model: combinational read, write on every edge while mem_rw is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h5A00_0000 | 32'(i);
    end else if (mem_rw) begin
      ram[ramIdx(mem_addr)] <= mem_wdata;
    end
  end

  assign mem_rdata  = ram[ramIdx(mem_addr)];
  assign mem_rdata2 = 32'h5A00_0000 | {24'h0, ramIdx(mem_addr2)};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one transaction on the main instance and measure what comes back.
  task automatic applyStimulus(input vec_t v, output int lat, output logic err,
                               output logic [31:0] rdata, output int rwCycles, output int addrBad);
    lat = 0; err = 1'bx; rdata = 'x; rwCycles = 0; addrBad = 0;
    @(negedge clk);
    if (v.port) begin
      ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_rw) begin
        rwCycles++;
        if (mem_addr !== v.addr || mem_wdata !== v.wdata) addrBad++;
      end
      if (v.port ? ls_ack : if_ack) begin
        lat   = k;
        err   = v.port ? ls_err : if_err;
        rdata = v.port ? ls_rdata : if_rdata;
        if (!v.expErr && mem_addr !== v.addr) addrBad++;
        break;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  initial begin
    int          lat, rwCycles, addrBad, rwCnt, nAck;
    logic        err;
    logic [31:0] rdata;
    int          ackTime [4];
    logic        ackPort [4];
    int          ackTime2 [2];
    logic [31:0] ackData2 [2];

    reset = 1'b1;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    if_req2 = 0; if_addr2 = 0; ls_req2 = 0; ls_we2 = 0; ls_addr2 = 0; ls_wdata2 = 0;

    //          port  we    addr          wdata         lat err  rdata         rw
    vecs[0]  = '{1'b1, 1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_0000, 2};
    vecs[1]  = '{1'b1, 1'b0, 32'h0100_0010, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0100_0010, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0900_0000, 32'hDEAD_BEEF, 1, 1'b1, 32'h0000_0000, 0};
    vecs[4]  = '{1'b1, 1'b1, 32'h0700_0020, 32'h1234_5678, 3, 1'b0, 32'hDEAD_BEEF, 2};
    vecs[5]  = '{1'b0, 1'b0, 32'h0700_0020, 32'h1234_5678, 3, 1'b0, 32'h1234_5678, 0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0800_0000, 32'h1234_5678, 1, 1'b1, 32'h0000_0000, 0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h1234_5678, 3, 1'b0, 32'h5A00_0001, 0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 3, 1'b0, 32'h5A00_0001, 2};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0004, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D, 0};
    vecs[10] = '{1'b1, 1'b1, 32'hFF00_0000, 32'hCAFE_F00D, 1, 1'b1, 32'h0000_0000, 0};
    vecs[11] = '{1'b0, 1'b0, 32'h07FF_FFFC, 32'hCAFE_F00D, 3, 1'b0, 32'h5A00_00FF, 0};

    repeat (3) @(negedge clk);
    checkOutput("reset if_ack", {31'b0, if_ack}, 32'h0);
    checkOutput("reset ls_ack", {31'b0, ls_ack}, 32'h0);
    checkOutput("reset mem_rw", {31'b0, mem_rw}, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset ls_rdata", ls_rdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], lat, err, rdata, rwCycles, addrBad);
      checkOutput($sformatf("v%0d ack latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d err", i), {31'b0, err}, {31'b0, vecs[i].expErr});
      checkOutput($sformatf("v%0d rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d mem_rw cycles", i), 32'(rwCycles), 32'(vecs[i].expRw));
      checkOutput($sformatf("v%0d bad ram addr/data", i), 32'(addrBad), 32'h0);
      @(negedge clk);
      checkOutput($sformatf("v%0d ack one cycle", i), {30'b0, if_ack, ls_ack}, 32'h0);
      checkOutput($sformatf("v%0d rdata held", i), vecs[i].port ? ls_rdata : if_rdata,
                  vecs[i].expRdata);
    end

    // Reset during the second ACCESS cycle of a write clears everything at once.
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0300_0000; ls_wdata = 32'h7777_7777;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("pre-reset mem_rw", {31'b0, mem_rw}, 32'h1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async reset mem_rw", {31'b0, mem_rw}, 32'h0);
    checkOutput("async reset mem_addr", mem_addr, 32'h0);
    checkOutput("async reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("async reset if_rdata", if_rdata, 32'h0);
    ls_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Both ports requesting continuously: IF first, then strict alternation.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0004;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0200_0000; ls_wdata = 32'h1111_1111;
    nAck = 0; rwCnt = 0;
    for (int i = 0; i < 4; i++) begin ackTime[i] = 0; ackPort[i] = 1'bx; end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (mem_rw) rwCnt++;
      if (if_ack && nAck < 4) begin ackTime[nAck] = k; ackPort[nAck] = 1'b0; nAck++; end
      if (ls_ack && nAck < 4) begin ackTime[nAck] = k; ackPort[nAck] = 1'b1; nAck++; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    checkOutput("tie ack count", 32'(nAck), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("tie ack%0d time", i), 32'(ackTime[i]), 32'(3 + 4 * i));
      checkOutput($sformatf("tie ack%0d port", i), {31'b0, ackPort[i]}, 32'(i % 2));
    end
    checkOutput("tie mem_rw cycles", 32'(rwCnt), 32'd4);
    checkOutput("tie if_rdata", if_rdata, 32'h5A00_0001);
    repeat (2) @(negedge clk);

    // Single-cycle access window: back-to-back reads with the request held high.
    @(negedge clk);
    ls_req2 = 1'b1; ls_we2 = 1'b0; ls_addr2 = 32'h0000_0004;
    nAck = 0; rwCnt = 0;
    ackTime2[0] = 0; ackTime2[1] = 0; ackData2[0] = 'x; ackData2[1] = 'x;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_rw2) rwCnt++;
      if (ls_ack2 && nAck < 2) begin
        ackTime2[nAck] = k;
        ackData2[nAck] = ls_rdata2;
        nAck++;
        if (nAck == 1) ls_addr2 = 32'h0700_0008;
        else ls_req2 = 1'b0;
      end
    end
    ls_req2 = 1'b0;
    checkOutput("ac1 ack0 time", 32'(ackTime2[0]), 32'd2);
    checkOutput("ac1 ack1 time", 32'(ackTime2[1]), 32'd5);
    checkOutput("ac1 chip0 data", ackData2[0], 32'h5A00_0001);
    checkOutput("ac1 chip7 data", ackData2[1], 32'h5A00_00E2);
    checkOutput("ac1 rdata held", ls_rdata2, 32'h5A00_00E2);
    checkOutput("ac1 mem_rw cycles", 32'(rwCnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester controller that shares the single 8-chip RAM block between the instruction-fetch port (port 0, read-only) and the load/store port (port 1, read/write).
- Serialises accesses with a round-robin grant and holds address, data and rw stable for a fixed access window, because the RAM is level-sensitive.
- Rejects addresses that decode to a non-existent chip.
- Sits between the CPU front end / execute stage and the RAM.

Parameters:
ADDR_W, 32, address width; bits [ADDR_W-1:ADDR_W-8] select the chip
DATA_W, 32, data width
NUM_CHIPS, 8, number of populated chips; chip index >= NUM_CHIPS is an error
ACCESS_CYCLES, 2, cycles the RAM inputs are held per access (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  port 0 request, held high until if_ack
if_addr  input  ADDR_W  port 0 address
if_ack  output  1  port 0 one-cycle completion pulse
if_rdata  output  DATA_W  port 0 read data, valid with if_ack, held until next if_ack
if_err  output  1  port 0 bad-address flag, valid with if_ack
ls_req  input  1  port 1 request, held high until ls_ack
ls_we  input  1  port 1 write (1) / read (0)
ls_addr  input  ADDR_W  port 1 address
ls_wdata  input  DATA_W  port 1 write data
ls_ack  output  1  port 1 one-cycle completion pulse
ls_rdata  output  DATA_W  port 1 read data, valid with ls_ack, held until next ls_ack
ls_err  output  1  port 1 bad-address flag, valid with ls_ack
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_rw  output  1  RAM write strobe (1 = write)
mem_rdata  input  DATA_W  RAM read data

Behaviour:
- Reset (async, active-high): state IDLE; last_grant = 1, so port 0 wins the first tie. All outputs are 0: acks, errs, rdata regs, mem_addr, mem_wdata, mem_rw.
- States:
  - IDLE: sample requests at the clock edge.
    - Neither request: stay in IDLE.
    - One request: grant it.
    - Both requests: grant the port != last_grant, then set last_grant.
  - On grant, latch port, addr, we and wdata (port 0 we = 0).
    - If the chip index (latched addr top 8 bits) >= NUM_CHIPS: go to RESP with err = 1.
    - Otherwise go to ACCESS; load counter = ACCESS_CYCLES-1.
  - ACCESS: mem_addr and mem_wdata are driven from the latched values; mem_rw = latched we.
    - Counter decrements each cycle.
    - At the edge where the counter = 0: capture mem_rdata into the granted port's rdata reg (reads only), then go to RESP.
  - RESP: mem_rw = 0. The granted port's ack = 1 for exactly this cycle; err = the latched error. Next state is always IDLE.
- RAM-side rules:
  - mem_rw is high only in ACCESS. It is registered, so it never glitches.
  - mem_addr and mem_wdata hold their last values in IDLE and RESP, so the level-sensitive RAM sees no spurious changes.
- Latency: ack is asserted ACCESS_CYCLES+1 cycles after the grant edge. Minimum request-to-request spacing is ACCESS_CYCLES+2 cycles (one IDLE bubble).
- Bad address: no RAM cycle is issued (mem_rw stays 0); ack arrives 1 cycle after grant; rdata reg is set to 0.
- Write completions leave that port's rdata reg unchanged; err = 0.
- Request dropped before ack: a protocol violation. The latched transaction still completes and acks.
- Request held high through its own ack cycle: treated as a new request at the next IDLE.
- Simultaneous requests with alternating demand: grants strictly alternate; neither port waits more than one access.
- Reset mid-ACCESS: immediate return to IDLE and mem_rw = 0. A partial write is possible; the requester re-issues after reset.
- Address bits below the chip field pass through untouched; chip-internal decode is the RAM's job.

Decomposition:
- Shared package (mem_pkg):
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2
  - port IDs: PORT_IF = 1'b0, PORT_LS = 1'b1
  - chip-select field position constant
- One natural sub-module, rr_arb2: 2-way round-robin picker holding last_grant, with a grant_en input.

Test Plan:
- Reset, then ls write (we = 1, addr 0x0100_0010, wdata 0xDEAD_BEEF) -> mem_rw high exactly 2 cycles with that addr/data; ls_ack pulses 3 cycles after the grant edge; ls_err = 0.
- ls read of 0x0100_0010 after that write -> ls_rdata = 0xDEAD_BEEF in the ack cycle, held afterwards; mem_rw stays 0.
- if_req and ls_req both high continuously from reset -> grant order IF, LS, IF, LS; each ack spaced 4 cycles apart; no mem_rw activity for IF.
- if read of addr 0x0900_0000 (chip 9) -> no ACCESS state, mem_rw = 0; if_ack one cycle after grant with if_err = 1 and if_rdata = 0.
- reset asserted on the 2nd ACCESS cycle of a write -> mem_rw = 0 and all outputs 0 immediately (asynchronously); a subsequent request completes normally, port 0 winning the tie.
- ACCESS_CYCLES = 1 variant, back-to-back ls reads of 0x0000_0004 and 0x0700_0008 -> acks 3 cycles apart, correct data from chips 0 and 7.
